// File: rtl/param_seq_detector.sv
// Parametrised Moore serial-pattern detector with runtime pattern
// reload, selectable overlap and a saturating match counter.
module param_seq_detector #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             load_pat,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [FW-1:0] LAST = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [PAT_W-1:0] pat, pat_n;
  logic [PAT_W-1:0] hist, hist_n;
  logic [PAT_W-1:0] nh;
  logic [FW-1:0]    fill, fill_n;
  logic             hit, z_n;
  logic [CNT_W-1:0] cnt_n;
  logic             sat_n;

  // Next pattern/history/fill and match decision.
  always_comb begin
    nh     = {hist[PAT_W-2:0], x};
    hit    = en && !load_pat && (nh == pat) && (fill >= LAST);
    pat_n  = pat;
    hist_n = hist;
    fill_n = fill;
    z_n    = 1'b0;
    unique case (1'b1)
      load_pat: begin
        pat_n  = pat_in;
        hist_n = '0;
        fill_n = '0;
      end
      (en && !load_pat): begin
        hist_n = nh;
        z_n    = hit;
        if (hit)
          fill_n = overlap ? FULL : '0;
        else if (fill == FULL)
          fill_n = FULL;
        else
          fill_n = fill + FW'(1);
      end
      default: ;
    endcase
  end

  // Counter update: clear beats a simultaneous match; saturate at max.
  always_comb begin
    cnt_n = match_cnt;
    if (clr_cnt)
      cnt_n = '0;
    else if (hit && (match_cnt != CMAX))
      cnt_n = match_cnt + CNT_W'(1);
    sat_n = (cnt_n == CMAX);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat       <= PATTERN;
      hist      <= '0;
      fill      <= '0;
      z         <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      pat       <= pat_n;
      hist      <= hist_n;
      fill      <= fill_n;
      z         <= z_n;
      match_cnt <= cnt_n;
      cnt_sat   <= sat_n;
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: directed table, CNT_W=2 corner
// sequence, and randomized stimulus against a queue-based model.
module tb_param_seq_detector;

  localparam int P = 3;
  localparam logic [P-1:0] DEF = 3'b101;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, x, overlap, load_pat, clr_cnt;
  logic [P-1:0] pat_in;
  logic         z, cnt_sat;
  logic [7:0]   match_cnt;

  logic         rst2, en2, x2, ov2, ld2, clr2;
  logic [2:0]   pi2;
  logic         z2, sat2;
  logic [1:0]   cnt2;

  param_seq_detector dut (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .overlap(overlap), .load_pat(load_pat),
    .pat_in(pat_in), .clr_cnt(clr_cnt),
    .z(z), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  param_seq_detector #(
    .PAT_W(3), .PATTERN(3'b111), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .x(x2),
    .overlap(ov2), .load_pat(ld2),
    .pat_in(pi2), .clr_cnt(clr2),
    .z(z2), .match_cnt(cnt2), .cnt_sat(sat2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the bits sampled since the last restart,
  // keeping only the newest P of them.
  logic [P-1:0] m_pat;
  bit           mq[$];
  int           m_cnt;
  bit           m_z;

  task automatic model_step();
    bit hit;
    logic [P-1:0] w;
    hit = 0;
    if (!rst) begin
      m_pat = DEF;
      mq.delete();
      m_z = 0;
      m_cnt = 0;
    end else begin
      if (load_pat) begin
        m_pat = pat_in;
        mq.delete();
        m_z = 0;
      end else if (en) begin
        mq.push_back(x);
        if (mq.size() > P) void'(mq.pop_front());
        if (mq.size() == P) begin
          for (int i = 0; i < P; i++) w[P-1-i] = mq[i];
          hit = (w == m_pat);
        end
        m_z = hit;
        if (hit && !overlap) mq.delete();
      end else begin
        m_z = 0;
      end
      if (clr_cnt) m_cnt = 0;
      else if (hit && m_cnt < MAXC) m_cnt++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit       rst, en, x, ov, ld;
    bit [2:0] pi;
    bit       clr;
    bit       ez;
    int       ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit xx, bit o,
                              bit l, bit [2:0] p, bit c,
                              bit ez, int ec);
    vec_t v;
    v.rst = r; v.en = e; v.x = xx; v.ov = o; v.ld = l;
    v.pi = p; v.clr = c; v.ez = ez; v.ec = ec;
    return v;
  endfunction

  initial begin
    rst = 0; en = 0; x = 0; overlap = 1;
    load_pat = 0; pat_in = '0; clr_cnt = 0;
    rst2 = 0; en2 = 0; x2 = 0; ov2 = 1;
    ld2 = 0; pi2 = '0; clr2 = 0;

    // reset, then overlapping 1,0,1,0,1
    tbl.push_back(mk(0,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 1,1));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,1));
    tbl.push_back(mk(1,1,1,1,0,0,0, 1,2));
    // non-overlapping 1,0,1,0,1,1,0,1
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,0,0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,0,0,0,0, 1,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, 0,1));
    tbl.push_back(mk(1,1,1,0,0,0,0, 0,1));
    tbl.push_back(mk(1,1,1,0,0,0,0, 0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, 0,1));
    tbl.push_back(mk(1,1,1,0,0,0,0, 1,2));
    // enable gaps: x=1 while en=0 must be ignored
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,0,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,0,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,0,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,0,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 1,1));
    tbl.push_back(mk(1,0,1,1,0,0,0, 0,1));
    // reload pattern 110 after 1,0
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,1,3'b110,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,1,0,0,0, 1,1));
    // clear wins over match, z still pulses
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,1));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,1));
    tbl.push_back(mk(1,1,0,1,0,0,1, 1,0));
    // reset mid-sequence after 1,0 (x=1 at reset ignored)
    tbl.push_back(mk(0,0,0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(0,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0));
    tbl.push_back(mk(1,1,1,1,0,0,0, 1,1));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; x = tbl[i].x;
      overlap = tbl[i].ov; load_pat = tbl[i].ld;
      pat_in = tbl[i].pi; clr_cnt = tbl[i].clr;
      tick();
      check($sformatf("vec%0d z", i), int'(z), int'(tbl[i].ez));
      check($sformatf("vec%0d cnt", i), int'(match_cnt), tbl[i].ec);
      check($sformatf("vec%0d sat", i), int'(cnt_sat), 0);
    end

    // CNT_W=2 saturation with pattern 111, clear on 7th sample
    rst = 1; en = 0; load_pat = 0; clr_cnt = 0;
    rst2 = 0;
    tick();
    check("sat2 reset cnt", int'(cnt2), 0);
    check("sat2 reset sat", int'(sat2), 0);
    begin
      int ez[7] = '{0,0,1,1,1,1,1};
      int ec[7] = '{0,0,1,2,3,3,0};
      int es[7] = '{0,0,0,0,1,1,0};
      rst2 = 1; en2 = 1; x2 = 1; ov2 = 1;
      for (int i = 0; i < 7; i++) begin
        clr2 = (i == 6);
        tick();
        check($sformatf("sat2 s%0d z", i+1), int'(z2), ez[i]);
        check($sformatf("sat2 s%0d cnt", i+1), int'(cnt2), ec[i]);
        check($sformatf("sat2 s%0d sat", i+1), int'(sat2), es[i]);
      end
      clr2 = 0; en2 = 0;
    end

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 149) != 0);
      load_pat = ($urandom_range(0, 39) == 0);
      en       = ($urandom_range(0, 3) != 0);
      x        = $urandom_range(0, 1);
      overlap  = $urandom_range(0, 1);
      pat_in   = P'($urandom_range(0, 7));
      clr_cnt  = ($urandom_range(0, 59) == 0);
      tick();
      check($sformatf("rnd%0d z", i), int'(z), int'(m_z));
      check($sformatf("rnd%0d cnt", i), int'(match_cnt), m_cnt);
      check($sformatf("rnd%0d sat", i), int'(cnt_sat),
            int'(m_cnt == MAXC));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
